// File: rtl/pixel_readout_pkg.sv
// Package: pixel_readout_pkg
// Purpose : Shared types and constants for the pixel readout block.
//   state_t      : readout FSM states (IDLE, CONVERT, UNLOAD)
//   ADC_BITS_DEF : default ramp/pixel code width
//   ROW_1/ROW_2  : encoding of the selected row on Pix_row
package pixel_readout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  localparam int   ADC_BITS_DEF = 8;
  localparam logic ROW_1        = 1'b0;
  localparam logic ROW_2        = 1'b1;

endpackage

// File: rtl/column_latch.sv
// Module : column_latch
// Purpose: One column of the single-slope ADC. Captures the ramp code on the
//          first cycle the column comparator reports Ramp >= pixel; a column
//          that never trips is forced to all-ones on the final ramp step.
// Ports  :
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear done flag and code (start of conversion or abort)
//   en       : conversion in progress
//   last     : ramp is at its final (all-ones) step
//   comp     : column comparator output
//   ramp     : current ramp code
//   code     : latched pixel code
module column_latch
  import pixel_readout_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                last,
  input  logic                comp,
  input  logic [ADC_BITS-1:0] ramp,
  output logic [ADC_BITS-1:0] code
);

  logic                done_reg;
  logic [ADC_BITS-1:0] code_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
      code_reg <= '0;
    end else if (clr) begin
      done_reg <= 1'b0;
      code_reg <= '0;
    end else if (en && !done_reg && (comp || last)) begin
      // A comparator hit wins over the end-of-ramp fill; both yield all-ones
      // on the last step anyway.
      done_reg <= 1'b1;
      code_reg <= comp ? ramp : '1;
    end
  end

  assign code = code_reg;

endmodule

// File: rtl/pixel_readout.sv
// Module : pixel_readout
// Purpose: Sensor-side responder to the camera controller. A rising ADC edge
//          with exactly one row selected runs a 2**ADC_BITS-cycle ramp,
//          latches one code per column, then streams the codes out over a
//          valid/ready interface. Erase aborts in any state.
// Ports  :
//   Clk, Reset            : clock, asynchronous active-high reset
//   Erase, Expose         : controller strobes (Erase aborts)
//   NRE_1, NRE_2          : active-low row read enables
//   ADC                   : conversion request, rising edge significant
//   Comp[COLS]            : column comparators (bit c high when Ramp >= pixel c)
//   Ramp                  : ramp DAC code
//   Pix_valid/ready/data/row/col : output word stream
//   Frame_done            : one-cycle pulse after the last row-2 word is accepted
//   Busy                  : FSM not idle
//   Seq_error             : sticky protocol error (only with PIXEL_SEQ_CHECK_EN)
// Build option: define PIXEL_SEQ_CHECK_EN to add the Seq_error port and checks.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int COLS     = 2,
  parameter int COL_W    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Erase,
  input  logic                Expose,
  input  logic                NRE_1,
  input  logic                NRE_2,
  input  logic                ADC,
  input  logic [COLS-1:0]     Comp,
  output logic [ADC_BITS-1:0] Ramp,
  output logic                Pix_valid,
  input  logic                Pix_ready,
  output logic [ADC_BITS-1:0] Pix_data,
  output logic                Pix_row,
  output logic [COL_W-1:0]    Pix_col,
  output logic                Frame_done,
  output logic                Busy
`ifdef PIXEL_SEQ_CHECK_EN
  ,
  output logic                Seq_error
`endif
);

  state_t              state_reg, state_next;
  logic                adc_q_reg;
  logic [ADC_BITS-1:0] ramp_reg;
  logic [COL_W-1:0]    col_reg;
  logic                row_reg;
  logic                frame_done_reg;

  logic                start;
  logic                one_row;
  logic                ramp_max;
  logic                accept;
  logic                last_col;
  logic                clr_latch;
  logic                conv_en;
  logic [ADC_BITS-1:0] code_arr [COLS];

  assign start    = ADC & ~adc_q_reg;
  assign one_row  = NRE_1 ^ NRE_2;
  assign ramp_max = (ramp_reg == '1);
  assign accept   = (state_reg == UNLOAD) && Pix_ready;
  assign last_col = (col_reg == COL_W'(COLS - 1));
  assign conv_en  = (state_reg == CONVERT) && !Erase;

  // Next-state logic; Erase overrides every state.
  always_comb begin
    state_next = state_reg;
    clr_latch  = 1'b0;
    if (Erase) begin
      state_next = IDLE;
      clr_latch  = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && one_row) begin
            state_next = CONVERT;
            clr_latch  = 1'b1;
          end
        end
        CONVERT: begin
          if (ramp_max) state_next = UNLOAD;
        end
        UNLOAD: begin
          if (accept && last_col) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      adc_q_reg      <= 1'b0;
      ramp_reg       <= '0;
      col_reg        <= '0;
      row_reg        <= ROW_1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      adc_q_reg <= ADC;

      // Ramp only moves in CONVERT and wraps to 0 on the final step.
      if (conv_en && !ramp_max) ramp_reg <= ramp_reg + ADC_BITS'(1);
      else                      ramp_reg <= '0;

      // Row is captured once at start; later NRE changes are ignored.
      if (!Erase && (state_reg == IDLE) && start && one_row)
        row_reg <= ~NRE_2;

      if (Erase || (state_reg == CONVERT)) col_reg <= '0;
      else if (accept)                     col_reg <= last_col ? '0 : col_reg + COL_W'(1);

      frame_done_reg <= !Erase && accept && last_col && (row_reg == ROW_2);
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    column_latch #(.ADC_BITS(ADC_BITS)) u_latch (
      .clk  (Clk),
      .rst  (Reset),
      .clr  (clr_latch),
      .en   (conv_en),
      .last (ramp_max),
      .comp (Comp[gi]),
      .ramp (ramp_reg),
      .code (code_arr[gi])
    );
  end

  // Word fields are zeroed outside UNLOAD so the stream is quiet when idle.
  assign Ramp       = ramp_reg;
  assign Pix_valid  = (state_reg == UNLOAD);
  assign Pix_data   = Pix_valid ? code_arr[col_reg] : '0;
  assign Pix_row    = Pix_valid & row_reg;
  assign Pix_col    = Pix_valid ? col_reg : '0;
  assign Frame_done = frame_done_reg;
  assign Busy       = (state_reg != IDLE);

`ifdef PIXEL_SEQ_CHECK_EN
  logic seq_error_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      seq_error_reg <= 1'b0;
    end else if ((start && (!one_row || (state_reg != IDLE))) ||
                 (Expose && Erase) || (!NRE_1 && !NRE_2)) begin
      seq_error_reg <= 1'b1;
    end
  end

  assign Seq_error = seq_error_reg;
`else
  // Expose only feeds the protocol checker.
  logic unused_expose;
  assign unused_expose = Expose;
`endif

endmodule
